// File: rtl/aud_i2s_tx.sv
// aud_i2s_tx -- single-clock stereo audio serialiser.
// Frames enter through a valid/ready FIFO and leave MSB-first on BCK/LRCK/DATA.
// Every audio clock is a clock-enable derived from iCLK_18_4.
// Optional feature macro: AUD_TX_UNDERRUN_CNT_EN adds the oUNDERRUN_CNT port
// and its saturating counter.
//
// Handshake: a frame transfers on every rising edge where iVALID && oREADY.
// oREADY depends only on the registered FIFO level, never on iVALID, and the
// source must hold iL_DATA/iR_DATA steady while iVALID is high and oREADY is low.
module aud_i2s_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 16,
  parameter int BCK_DIV    = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int I2S_MODE   = 1
) (
  input  logic                          iCLK_18_4,
  input  logic                          iRST_N,
  input  logic                          iEnable,
  input  logic [DATA_WIDTH-1:0]         iL_DATA,
  input  logic [DATA_WIDTH-1:0]         iR_DATA,
  input  logic                          iVALID,
  output logic                          oREADY,
  output logic [$clog2(FIFO_DEPTH):0]   oFIFO_LEVEL,
  output logic                          oAUD_BCK,
  output logic                          oAUD_LRCK,
  output logic                          oAUD_DATA,
  output logic                          oUNDERRUN
`ifdef AUD_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   oUNDERRUN_CNT
`endif
);

  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int DIV_W      = $clog2(BCK_DIV);
  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int PAD_BITS   = SLOT_WIDTH - DATA_WIDTH;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                   state;
  logic                     started_q;
  logic [DIV_W-1:0]         div_q;
  logic                     bck_q;
  logic [CNT_W-1:0]         bit_cnt_q;
  logic [FRAME_BITS-1:0]    shifter_q;
  logic                     data_q;
  logic                     underrun_q;

  logic [2*DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic [LVL_W-1:0]         level_q;

  logic                     run;
  logic                     div_wrap;
  logic                     bck_fall;
  logic                     first_run;
  logic                     frame_end;
  logic                     load_evt;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic [DATA_WIDTH-1:0]    head_l;
  logic [DATA_WIDTH-1:0]    head_r;
  logic [SLOT_WIDTH-1:0]    slot_l;
  logic [SLOT_WIDTH-1:0]    slot_r;

  // Timing strobes: all audio clocks are enables inside the iCLK_18_4 domain.
  assign run        = (state == ST_RUN);
  assign div_wrap   = run && (div_q == DIV_W'(BCK_DIV - 1));
  assign bck_fall   = div_wrap && bck_q;
  assign first_run  = run && !started_q;
  assign frame_end  = (bit_cnt_q == CNT_W'(FRAME_BITS - 1));
  assign load_evt   = first_run || (bck_fall && frame_end);

  // FIFO control: no bypass, so a pop only ever sees frames already stored.
  assign fifo_empty = (level_q == '0);
  assign oREADY     = (level_q < LVL_W'(FIFO_DEPTH));
  assign push       = iVALID && oREADY;
  assign pop        = load_evt && !fifo_empty;

  // Samples are left-aligned in their slots; the low PAD_BITS stay zero.
  assign {head_l, head_r} = mem[rd_ptr_q];
  assign slot_l = SLOT_WIDTH'(head_l) << PAD_BITS;
  assign slot_r = SLOT_WIDTH'(head_r) << PAD_BITS;

  // Run/idle state follows iEnable one cycle late.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) state <= ST_IDLE;
    else         state <= iEnable ? ST_RUN : ST_IDLE;
  end

  // FIFO storage written on every accepted frame.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr_q] <= {iL_DATA, iR_DATA};
    end
  end

  // FIFO pointers and level; simultaneous push and pop cancel in the level.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // BCK divider and bit counter; leaving RUN aborts the frame at once.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      started_q <= 1'b0;
      div_q     <= '0;
      bck_q     <= 1'b0;
      bit_cnt_q <= '0;
    end else if (!run) begin
      started_q <= 1'b0;
      div_q     <= '0;
      bck_q     <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      started_q <= 1'b1;
      div_q     <= div_wrap ? '0 : div_q + DIV_W'(1);
      if (div_wrap) bck_q <= ~bck_q;
      if (bck_fall) bit_cnt_q <= frame_end ? '0 : bit_cnt_q + CNT_W'(1);
    end
  end

  // Frame shifter, one-BCK delay register for I2S framing, underrun strobe.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      shifter_q  <= '0;
      data_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else if (!run) begin
      shifter_q  <= '0;
      data_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (bck_fall) data_q <= shifter_q[FRAME_BITS-1];
      if (load_evt) shifter_q <= pop ? {slot_l, slot_r} : '0;
      else if (bck_fall) shifter_q <= {shifter_q[FRAME_BITS-2:0], 1'b0};
      underrun_q <= load_evt && fifo_empty;
    end
  end

`ifdef AUD_TX_UNDERRUN_CNT_EN
  logic [15:0] und_cnt_q;

  // Saturating underrun tally, cleared only by reset.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) und_cnt_q <= '0;
    else if (underrun_q && (und_cnt_q != 16'hFFFF)) und_cnt_q <= und_cnt_q + 16'd1;
  end

  assign oUNDERRUN_CNT = und_cnt_q;
`endif

  assign oFIFO_LEVEL = level_q;
  assign oAUD_BCK    = bck_q;
  assign oAUD_LRCK   = (bit_cnt_q >= CNT_W'(SLOT_WIDTH));
  assign oAUD_DATA   = (I2S_MODE != 0) ? data_q : shifter_q[FRAME_BITS-1];
  assign oUNDERRUN   = underrun_q;

endmodule

// File: tb/tb_aud_i2s_tx.sv
// tb_aud_i2s_tx -- bench for aud_i2s_tx.
// dut_a: default parameters (16/16, BCK_DIV 6, I2S framing).
// dut_b: DATA_WIDTH 24, SLOT_WIDTH 32, BCK_DIV 3, left-justified framing.
// Serial output is captured on BCK rises and decoded back into frames from the
// slot layout, then compared against the queue of frames pushed by the bench.
module tb_aud_i2s_tx;

  localparam int A_DW = 16;
  localparam int A_SW = 16;
  localparam int B_DW = 24;
  localparam int B_SW = 32;
  localparam int FRAME_CLKS = 384;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        en_a = 1'b0, valid_a = 1'b0;
  logic [15:0] l_a = '0, r_a = '0;
  logic        ready_a, bck_a, lrck_a, data_a, und_a;
  logic [2:0]  level_a;
  logic        en_b = 1'b0, valid_b = 1'b0;
  logic [23:0] l_b = '0, r_b = '0;
  logic        ready_b, bck_b, lrck_b, data_b, und_b;
  logic [2:0]  level_b;
`ifdef AUD_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_a, ucnt_b;
`endif

  aud_i2s_tx dut_a (
    .iCLK_18_4(clk), .iRST_N(rst_n), .iEnable(en_a),
    .iL_DATA(l_a), .iR_DATA(r_a), .iVALID(valid_a), .oREADY(ready_a),
    .oFIFO_LEVEL(level_a), .oAUD_BCK(bck_a), .oAUD_LRCK(lrck_a),
    .oAUD_DATA(data_a), .oUNDERRUN(und_a)
`ifdef AUD_TX_UNDERRUN_CNT_EN
    , .oUNDERRUN_CNT(ucnt_a)
`endif
  );

  aud_i2s_tx #(
    .DATA_WIDTH(B_DW), .SLOT_WIDTH(B_SW), .BCK_DIV(3), .FIFO_DEPTH(4), .I2S_MODE(0)
  ) dut_b (
    .iCLK_18_4(clk), .iRST_N(rst_n), .iEnable(en_b),
    .iL_DATA(l_b), .iR_DATA(r_b), .iVALID(valid_b), .oREADY(ready_b),
    .oFIFO_LEVEL(level_b), .oAUD_BCK(bck_b), .oAUD_LRCK(lrck_b),
    .oAUD_DATA(data_b), .oUNDERRUN(und_b)
`ifdef AUD_TX_UNDERRUN_CNT_EN
    , .oUNDERRUN_CNT(ucnt_b)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  logic        bits_a[$], lr_a[$], bits_b[$], lr_b[$];
  int          und_t_a[$], lrf_b[$];
  int          und_cnt_a = 0, und_cnt_b = 0;
  int          idle_bad = 0;
  logic        idle_mon = 1'b0;
  logic [31:0] dec_l[$], dec_r[$];
  int          dec_pad_bad, dec_lr_bad;
  int          vectors = 0, miscompares = 0;

  // ---------------- pin monitor ----------------
  logic bck_a_prev = 1'b0, bck_b_prev = 1'b0, lrck_b_prev = 1'b0;
  always @(negedge clk) begin
    bck_a_prev  <= bck_a;
    bck_b_prev  <= bck_b;
    lrck_b_prev <= lrck_b;
    if (bck_a && !bck_a_prev) begin bits_a.push_back(data_a); lr_a.push_back(lrck_a); end
    if (bck_b && !bck_b_prev) begin bits_b.push_back(data_b); lr_b.push_back(lrck_b); end
    if (lrck_b_prev && !lrck_b) lrf_b.push_back(cyc);
    if (und_a) begin und_cnt_a <= und_cnt_a + 1; und_t_a.push_back(cyc); end
    if (und_b) und_cnt_b <= und_cnt_b + 1;
    if (idle_mon && (bck_a || lrck_a || data_a || bck_b || lrck_b || data_b))
      idle_bad <= idle_bad + 1;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_bit(input int sel, input int idx);
    return (sel == 0) ? bits_a[idx] : bits_b[idx];
  endfunction

  function automatic logic get_lr(input int sel, input int idx);
    return (sel == 0) ? lr_a[idx] : lr_b[idx];
  endfunction

  // Driver: hold a frame on the input until the FIFO takes it.
  task automatic push_frame(input int sel, input logic [31:0] l, input logic [31:0] r);
    int t;
    t = 0;
    if (sel == 0) begin valid_a = 1'b1; l_a = l[15:0]; r_a = r[15:0]; end
    else          begin valid_b = 1'b1; l_b = l[23:0]; r_b = r[23:0]; end
    while (((sel == 0) ? !ready_a : !ready_b) && t < 2000) begin tick(); t++; end
    check("push_wait", 64'(t < 2000), 64'(1));
    tick();
    if (sel == 0) valid_a = 1'b0; else valid_b = 1'b0;
    exp_q.push_back({l, r});
  endtask

  // Reference model: split the captured bit stream into frames. A frame starts
  // at the first BCK with LRCK=0 after LRCK=1; left slot is LRCK=0, right is
  // LRCK=1, samples MSB-first then zero padding. I2S framing shifts data one BCK.
  task automatic decode(input int sel, input int sw, input int dw, input bit i2s);
    int n, off;
    logic b;
    logic [31:0] l, r;
    dec_l.delete(); dec_r.delete();
    dec_pad_bad = 0; dec_lr_bad = 0;
    n   = (sel == 0) ? bits_a.size() : bits_b.size();
    off = i2s ? 1 : 0;
    for (int i = 0; i + 2 * sw - 1 + off < n; i++) begin
      if (get_lr(sel, i) == 1'b0 && (i == 0 || get_lr(sel, i - 1) == 1'b1)) begin
        l = '0;
        r = '0;
        for (int k = 0; k < 2 * sw; k++) begin
          b = get_bit(sel, i + k + off);
          if (get_lr(sel, i + k) !== ((k >= sw) ? 1'b1 : 1'b0)) dec_lr_bad++;
          if (k < dw) l = {l[30:0], b};
          else if (k >= sw && k < sw + dw) r = {r[30:0], b};
          else if (b !== 1'b0) dec_pad_bad++;
        end
        dec_l.push_back(l);
        dec_r.push_back(r);
      end
    end
  endtask

  task automatic compare_frames(input string tag);
    check({tag, "_count"}, 64'(dec_l.size() >= exp_q.size()), 64'(1));
    for (int j = 0; j < exp_q.size() && j < dec_l.size(); j++)
      check($sformatf("%s%0d", tag, j), {dec_l[j], dec_r[j]}, exp_q[j]);
    check({tag, "_pad"}, 64'(dec_pad_bad), 64'(0));
    check({tag, "_lrck"}, 64'(dec_lr_bad), 64'(0));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int          t, accepted, ub;
    logic        rdy;
    logic [31:0] fl[5], fr[5], l6, r6, msk;

    // Reset values
    cycles(3);
    check("rst_a_pins", 64'({bck_a, lrck_a, data_a, und_a}), 64'(0));
    check("rst_b_pins", 64'({bck_b, lrck_b, data_b, und_b}), 64'(0));
    check("rst_a_level", 64'(level_a), 64'(0));
    check("rst_b_level", 64'(level_b), 64'(0));
    check("rst_ready", 64'({ready_a, ready_b}), 64'(2'b11));
`ifdef AUD_TX_UNDERRUN_CNT_EN
    check("rst_ucnt", 64'({ucnt_a, ucnt_b}), 64'(0));
`endif

    // Idle after release: audio pins stay low
    rst_n = 1'b1;
    idle_mon = 1'b1;
    cycles(1000);
    idle_mon = 1'b0;
    check("idle_quiet", 64'(idle_bad), 64'(0));

    // dut_a: fill FIFO with iVALID held, backpressure, I2S data, underruns
    exp_q.delete(); bits_a.delete(); lr_a.delete(); und_t_a.delete();
    fl[0] = 32'h0000A5F0;
    fr[0] = 32'h00000F0F;
    for (int i = 1; i < 5; i++) begin
      fl[i] = $urandom_range(0, 65535);
      fr[i] = $urandom_range(0, 65535);
    end
    accepted = 0;
    valid_a = 1'b1; l_a = fl[0][15:0]; r_a = fr[0][15:0];
    for (int c = 0; c < 20; c++) begin
      rdy = ready_a;
      tick();
      if (rdy && accepted < 5) begin
        exp_q.push_back({fl[accepted], fr[accepted]});
        accepted++;
        if (accepted < 5) begin l_a = fl[accepted][15:0]; r_a = fr[accepted][15:0]; end
      end
    end
    check("fill_accepted", 64'(accepted), 64'(4));
    check("fill_level", 64'(level_a), 64'(4));
    check("fill_ready", 64'(ready_a), 64'(0));

    en_a = 1'b1;
    t = 0;
    while (!ready_a && t < 50) begin tick(); t++; end
    check("ready_rise_latency", 64'(t), 64'(2));
    tick();
    if (accepted < 5) begin exp_q.push_back({fl[4], fr[4]}); accepted++; end
    valid_a = 1'b0;
    check("refill_level", 64'(level_a), 64'(4));

    t = 0;
    while (und_cnt_a < 3 && t < 4000) begin tick(); t++; end
    check("underrun_count", 64'(und_cnt_a), 64'(3));
    check("underrun_gap1", 64'(und_t_a[1] - und_t_a[0]), 64'(FRAME_CLKS));
    check("underrun_gap2", 64'(und_t_a[2] - und_t_a[1]), 64'(FRAME_CLKS));
    check("drained_level", 64'(level_a), 64'(0));
`ifdef AUD_TX_UNDERRUN_CNT_EN
    check("ucnt_a_three", 64'(ucnt_a), 64'(3));
`endif
    for (int i = 0; i < 3; i++) exp_q.push_back(64'(0));
    l6 = $urandom_range(0, 65535);
    r6 = $urandom_range(0, 65535);
    push_frame(0, l6, r6);
    cycles(400);
    check("no_underrun_after_push", 64'(und_cnt_a), 64'(3));
    cycles(400);
    en_a = 1'b0;
    tick();
    decode(0, A_SW, A_DW, 1'b1);
    check("i2s_first_bit", 64'(bits_a[0]), 64'(0));
    compare_frames("a_frame");

    // dut_b: left-justified, 24-bit samples in 32-bit slots
    exp_q.delete(); bits_b.delete(); lr_b.delete(); lrf_b.delete();
    ub = und_cnt_b;
    push_frame(1, 32'h00A5F0C3, 32'h000F0F3C);
    push_frame(1, $urandom_range(0, 24'hFFFFFF), $urandom_range(0, 24'hFFFFFF));
    push_frame(1, $urandom_range(0, 24'hFFFFFF), $urandom_range(0, 24'hFFFFFF));
    exp_q.push_back(64'(0));
    en_b = 1'b1;
    t = 0;
    while (und_cnt_b - ub < 2 && t < 3000) begin tick(); t++; end
    en_b = 1'b0;
    tick();
    check("b_underruns", 64'(und_cnt_b - ub), 64'(2));
    check("b_level", 64'(level_b), 64'(0));
    check("b_lrck_period", 64'(lrf_b[1] - lrf_b[0]), 64'(FRAME_CLKS));
`ifdef AUD_TX_UNDERRUN_CNT_EN
    check("ucnt_b_two", 64'(ucnt_b), 64'(2));
`endif
    decode(1, B_SW, B_DW, 1'b0);
    compare_frames("b_frame");

    // Random frames with random push gaps, both framings
    for (int s = 0; s < 2; s++) begin
      exp_q.delete();
      bits_a.delete(); lr_a.delete(); bits_b.delete(); lr_b.delete();
      msk = (s == 0) ? 32'h0000FFFF : 32'h00FFFFFF;
      for (int k = 0; k < 4; k++) push_frame(s, $urandom() & msk, $urandom() & msk);
      ub = (s == 0) ? und_cnt_a : und_cnt_b;
      if (s == 0) en_a = 1'b1; else en_b = 1'b1;
      for (int k = 0; k < 2; k++) begin
        cycles($urandom_range(0, 50));
        push_frame(s, $urandom() & msk, $urandom() & msk);
      end
      t = 0;
      while ((((s == 0) ? und_cnt_a : und_cnt_b) == ub) && t < 4000) begin tick(); t++; end
      check("rand_underrun", 64'(((s == 0) ? und_cnt_a : und_cnt_b) - ub), 64'(1));
      cycles(30);
      en_a = 1'b0; en_b = 1'b0;
      tick();
      decode(s, (s == 0) ? A_SW : B_SW, (s == 0) ? A_DW : B_DW, s == 0);
      compare_frames((s == 0) ? "rand_a" : "rand_b");
    end

    // Asynchronous reset in the middle of a frame
    push_frame(0, $urandom_range(0, 65535), $urandom_range(0, 65535));
    push_frame(0, $urandom_range(0, 65535), $urandom_range(0, 65535));
    push_frame(1, $urandom_range(0, 24'hFFFFFF), $urandom_range(0, 24'hFFFFFF));
    check("pre_reset_level_a", 64'(level_a), 64'(2));
    en_a = 1'b1; en_b = 1'b1;
    cycles(100);
    check("pre_reset_level_run", 64'(level_a), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_a_pins", 64'({bck_a, lrck_a, data_a, und_a}), 64'(0));
    check("async_rst_b_pins", 64'({bck_b, lrck_b, data_b, und_b}), 64'(0));
    check("async_rst_levels", 64'({level_a, level_b}), 64'(0));
`ifdef AUD_TX_UNDERRUN_CNT_EN
    check("async_rst_ucnt", 64'({ucnt_a, ucnt_b}), 64'(0));
`endif
    tick();
    en_a = 1'b0; en_b = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_reset_ready", 64'({ready_a, ready_b}), 64'(2'b11));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aud_i2s_tx.md
# aud_i2s_tx

Parametrised single-clock audio serial transmitter that accepts stereo sample frames over a valid/ready handshake, buffers them in an internal FIFO and serialises them MSB-first on BCK/LRCK/DATA to the codec. It supersedes fixed 16-bit/48 kHz DAC serialisers by generating every audio clock as a clock-enable inside one domain. It also adds selectable I2S/left-justified framing, configurable data and slot widths, and explicit underrun handling. It sits between the sample source (sine ROM, FLASH/SDRAM/SRAM readers) and the codec pins.

## Interface
- DATA_WIDTH, 16, sample bits per channel (8..32)
- SLOT_WIDTH, 16, BCK periods per channel slot; must be >= DATA_WIDTH
- BCK_DIV, 6, iCLK_18_4 cycles per BCK half-period (>= 2)
- FIFO_DEPTH, 4, stereo frames buffered; power of 2, >= 2
- I2S_MODE, 1, 1 = Philips I2S (data one BCK after LRCK edge), 0 = left-justified

Ports:
- iCLK_18_4  in  1  sole clock; one clock, all logic on its rising edge
- iRST_N  in  1  reset, asynchronous, active-low
- iEnable  in  1  1 = transmit, 0 = idle
- iL_DATA  in  DATA_WIDTH  left sample (two's complement)
- iR_DATA  in  DATA_WIDTH  right sample
- iVALID  in  1  frame valid
- oREADY  out  1  FIFO can accept a frame
- oFIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  frames held
- oAUD_BCK  out  1  bit clock
- oAUD_LRCK  out  1  0 = left slot, 1 = right slot
- oAUD_DATA  out  1  serial data, changes on BCK falling edge
- oUNDERRUN  out  1  one-cycle pulse per frame loaded with FIFO empty
- oUNDERRUN_CNT  out  16  only with AUD_TX_UNDERRUN_CNT_EN

## Operation
- States: IDLE (iEnable=0) and RUN (iEnable=1), registered from iEnable.
- IDLE: divider, bit counter, BCK, LRCK, DATA held 0; shifter cleared; FIFO keeps accepting.
- RUN: divider counts 0..BCK_DIV-1; at BCK_DIV-1 it wraps and BCK toggles. First BCK rise is BCK_DIV cycles after entering RUN. bck_fall = wrap cycle with BCK=1.
- Bit counter 0..2*SLOT_WIDTH-1 advances on bck_fall and wraps. LRCK = (bit_cnt >= SLOT_WIDTH).
- Frame load event: first RUN cycle, or bck_fall with bit_cnt = 2*SLOT_WIDTH-1.
- At a load event: if FIFO is non-empty, pop one frame into a 2*SLOT_WIDTH shifter as {L, zeros, R, zeros}, samples left-aligned. If the FIFO is empty, load all zeros and pulse oUNDERRUN.
- The shifter shifts left on every bck_fall that is not a load event.
- I2S_MODE=0: oAUD_DATA = shifter MSB.
- I2S_MODE=1: oAUD_DATA = shifter MSB delayed one BCK (register updated on bck_fall). The right-slot LSB therefore appears in bit 0 of the next frame.
- FIFO: push on iVALID && oREADY. oREADY = (level < FIFO_DEPTH), registered-level based. A pop and a push in the same cycle leave the level unchanged.
- There is no empty-FIFO bypass: a push coinciding with a load event on an empty FIFO still causes an underrun. The pushed frame is sent next frame.
- RUN→IDLE mid-frame: abort immediately; the frame in the shifter is discarded and FIFO contents are kept.
- iRST_N low at any time: all registers cleared, FIFO emptied, all outputs 0 (oREADY=1 after release).

## Timing
- BCK period = 2*BCK_DIV clocks; frame = 2*SLOT_WIDTH BCK = 384 clocks at defaults (48 kHz from 18.432 MHz).
- Pop-to-first-bit: MSB is valid from the load-event cycle +1 (LJ) or +2*BCK_DIV (I2S).
- oREADY rises the cycle after a pop from a full FIFO.
- oUNDERRUN is high exactly one cycle: the cycle after the load event.

## Configuration
- AUD_TX_UNDERRUN_CNT_EN defined: oUNDERRUN_CNT exists. It increments on each oUNDERRUN pulse, saturates at 65535 and is cleared only by iRST_N.
- AUD_TX_UNDERRUN_CNT_EN undefined: the port and counter are absent; oUNDERRUN behaviour is unchanged.

## Test plan
- Reset (defaults): all outputs 0 except oREADY=1; oFIFO_LEVEL=0; release, iEnable=0 for 1000 cycles -> BCK/LRCK/DATA stay 0.
- I2S_MODE=0, push L=16'hA5F0, R=16'h0F0F, then iEnable=1 -> data sampled on BCK rises reads A5F0 while LRCK=0 and 0F0F while LRCK=1; LRCK period 384 clocks; level returns to 0.
- I2S_MODE=1, same frame -> first BCK rise after LRCK fall carries 0, then A5F0 MSB-first; right LSB (1) appears at bit 0 of the following frame.
- Enable with empty FIFO (macro on) -> oUNDERRUN pulses every 384 clocks, DATA stays 0; oUNDERRUN_CNT=3 after third frame; push a frame -> sent next frame, no pulse.
- Hold iVALID for 5 frames while idle -> oREADY drops after 4 accepted, level=4. Enable -> oREADY high one cycle after first pop; fifth frame accepted.
- SLOT_WIDTH=32, DATA_WIDTH=24, BCK_DIV=3 -> LRCK period 384 clocks, 8 trailing zero bits per slot. Assert iRST_N low mid-frame -> outputs 0 asynchronously, FIFO empty.
